// File: rtl/fir_pkg.sv
// Shared types and default sizes for the FIR sample sequencer.
package fir_pkg;

  localparam int FIR_ADDR_WIDTH = 5;
  localparam int FIR_DATA_WIDTH = 16;
  localparam int FIR_N_TAPS     = 32;

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, READ, DRAIN} seq_state_t;

endpackage

// File: rtl/fir_sample_sequencer.sv
// Drives the single-port sample RAM: zero-fills it after reset, writes each new sample into a
// circular history, then reads the newest N_TAPS samples back newest-first for the MAC.
module fir_sample_sequencer
  import fir_pkg::*;
#(
  parameter int ADDR_WIDTH = FIR_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int N_TAPS     = FIR_N_TAPS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_adres,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wr,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  smp_valid,
  output logic [DATA_WIDTH-1:0] smp_data,
  output logic [ADDR_WIDTH-1:0] tap_idx,
  output logic                  smp_first,
  output logic                  smp_last
);

  localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(N_TAPS - 1);
  localparam logic [ADDR_WIDTH:0]   CLR_DONE = (ADDR_WIDTH + 1)'(DEPTH);

  if (N_TAPS < 1 || N_TAPS > DEPTH) begin : g_taps_range
    $error("fir_sample_sequencer: N_TAPS must lie in 1..2**ADDR_WIDTH");
  end

  seq_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_tap;
  logic [ADDR_WIDTH:0]   r_clr_cnt;
  logic                  w_last_tap;

  assign w_last_tap = (r_tap == LAST_TAP);
  assign in_ready   = (r_state == IDLE);
  assign smp_data   = ram_data_out;

  // The clear counter is one bit wider so the cycle after the last clear write is the IDLE entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_wr_ptr  <= '0;
      r_tap     <= '0;
      r_clr_cnt <= '0;
      ram_wr    <= 1'b0;
      ram_adres <= '0;
      ram_data  <= '0;
      smp_valid <= 1'b0;
      smp_first <= 1'b0;
      smp_last  <= 1'b0;
      tap_idx   <= '0;
    end else begin
      smp_valid <= 1'b0;
      smp_first <= 1'b0;
      smp_last  <= 1'b0;
      case (r_state)
        CLEAR: begin
          if (r_clr_cnt == CLR_DONE) begin
            ram_wr  <= 1'b0;
            r_state <= IDLE;
          end else begin
            ram_wr    <= 1'b1;
            ram_data  <= '0;
            ram_adres <= r_clr_cnt[ADDR_WIDTH-1:0];
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (in_valid) begin
            ram_wr    <= 1'b1;
            ram_adres <= r_wr_ptr;
            ram_data  <= in_data;
            r_state   <= WRITE;
          end
        end
        WRITE: begin
          ram_wr    <= 1'b0;
          ram_data  <= '0;
          ram_adres <= r_wr_ptr;
          r_tap     <= '0;
          r_state   <= READ;
        end
        READ: begin
          // Flags describe the address issued this cycle; they line up with the RAM's registered data.
          smp_valid <= 1'b1;
          tap_idx   <= r_tap;
          smp_first <= (r_tap == '0);
          smp_last  <= w_last_tap;
          if (w_last_tap) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_state  <= DRAIN;
          end else begin
            r_tap     <= r_tap + 1'b1;
            ram_adres <= r_wr_ptr - r_tap - 1'b1;
          end
        end
        DRAIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Randomized self-checking bench: two sequencers (N_TAPS=4 and N_TAPS=1), each with a behavioural RAM.
module tb_fir_sample_sequencer;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int NT    = 4;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inValid, inReady, ramWr, smpValid, smpFirst, smpLast;
  logic [DW-1:0] inData, ramData, ramDataOut, smpData;
  logic [AW-1:0] ramAdres, tapIdx;
  logic          inValidB, inReadyB, ramWrB, smpValidB, smpFirstB, smpLastB;
  logic [DW-1:0] inDataB, ramDataB, ramDataOutB, smpDataB;
  logic [AW-1:0] ramAdresB, tapIdxB;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  int vectors = 0;
  int miscompares = 0;
  int cycleCnt = 0;
  int lastAccept = 0;
  bit heldPrev = 1'b0;
  int histQ[$];
  int nAccB = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  fir_sample_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_TAPS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_data(inData), .in_ready(inReady),
    .ram_adres(ramAdres), .ram_data(ramData), .ram_wr(ramWr), .ram_data_out(ramDataOut),
    .smp_valid(smpValid), .smp_data(smpData), .tap_idx(tapIdx),
    .smp_first(smpFirst), .smp_last(smpLast)
  );

  fir_sample_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_TAPS(1)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(inValidB), .in_data(inDataB), .in_ready(inReadyB),
    .ram_adres(ramAdresB), .ram_data(ramDataB), .ram_wr(ramWrB), .ram_data_out(ramDataOutB),
    .smp_valid(smpValidB), .smp_data(smpDataB), .tap_idx(tapIdxB),
    .smp_first(smpFirstB), .smp_last(smpLastB)
  );

  // Behavioural RAMs: scrambled while reset is low so only the sequencer's clear can zero them.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem0[i] <= DW'($urandom);
    end else if (ramWr) begin
      mem0[ramAdres] <= ramData;
    end else begin
      ramDataOut <= mem0[ramAdres];
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem1[i] <= DW'($urandom);
    end else if (ramWrB) begin
      mem1[ramAdresB] <= ramDataB;
    end else begin
      ramDataOutB <= mem1[ramAdresB];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleCnt);
    end
  endtask

  function automatic int wrapAddr(input int a);
    return ((a % DEPTH) + DEPTH) % DEPTH;
  endfunction

  // Called at the negedge of a cycle in which reset is low; releases reset and follows the clear.
  task automatic checkClear();
    checkOutput("rstWr", ramWr, 0);
    checkOutput("rstAddr", ramAdres, 0);
    checkOutput("rstData", ramData, 0);
    checkOutput("rstReady", inReady, 0);
    checkOutput("rstSmp", {smpValid, smpFirst, smpLast}, 0);
    checkOutput("rstTap", tapIdx, 0);
    checkOutput("rstReadyB", inReadyB, 0);
    histQ.delete();
    nAccB = 0;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checkOutput("clrWr", ramWr, 1);
      checkOutput("clrAddr", ramAdres, i);
      checkOutput("clrData", ramData, 0);
      checkOutput("clrReady", inReady, 0);
      checkOutput("clrSmp", smpValid, 0);
    end
    @(negedge clk);
    checkOutput("clrDoneReady", inReady, 1);
    checkOutput("clrDoneWr", ramWr, 0);
  endtask

  // Offers one sample, then checks the write, every read address and the returned history.
  task automatic applyStimulus(input logic [DW-1:0] value, input bit hold);
    int waitCnt;
    int n;
    int k;
    int idx;
    int expData;
    inValid = 1'b1;
    inData  = value;
    waitCnt = 0;
    while (inReady !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (inReady !== 1'b1) begin
      checkOutput("readyTimeout", inReady, 1);
      inValid = 1'b0;
      return;
    end
    if (heldPrev) checkOutput("streamGap", cycleCnt - lastAccept, NT + 3);
    lastAccept = cycleCnt;
    heldPrev   = hold;
    histQ.push_back(int'(value));
    n = histQ.size() - 1;
    @(negedge clk);
    inValid = hold;
    inData  = DW'($urandom);
    checkOutput("wrEn", ramWr, 1);
    checkOutput("wrAddr", ramAdres, wrapAddr(n));
    checkOutput("wrData", ramData, value);
    checkOutput("wrReady", inReady, 0);
    for (int c = 2; c <= NT + 2; c++) begin
      @(negedge clk);
      checkOutput("busyReady", inReady, 0);
      if (c <= NT + 1) begin
        checkOutput("rdEn", ramWr, 0);
        checkOutput("rdAddr", ramAdres, wrapAddr(n - (c - 2)));
      end
      if (c >= 3) begin
        k = c - 3;
        idx = n - k;
        expData = (idx >= 0) ? histQ[idx] : 0;
        checkOutput("smpValid", smpValid, 1);
        checkOutput("smpData", smpData, expData);
        checkOutput("tapIdx", tapIdx, k);
        checkOutput("smpFirst", smpFirst, (k == 0) ? 1 : 0);
        checkOutput("smpLast", smpLast, (k == NT - 1) ? 1 : 0);
      end else begin
        checkOutput("smpEarly", smpValid, 0);
      end
    end
    @(negedge clk);
    checkOutput("readyBack", inReady, 1);
    checkOutput("smpDone", smpValid, 0);
  endtask

  task automatic idleGap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Single-tap instance: every sample yields exactly one first-and-last sample equal to itself.
  task automatic applyStimulusB(input logic [DW-1:0] value);
    int waitCnt;
    inValidB = 1'b1;
    inDataB  = value;
    waitCnt  = 0;
    while (inReadyB !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (inReadyB !== 1'b1) begin
      checkOutput("readyTimeoutB", inReadyB, 1);
      inValidB = 1'b0;
      return;
    end
    @(negedge clk);
    inValidB = 1'b0;
    checkOutput("wrEnB", ramWrB, 1);
    checkOutput("wrAddrB", ramAdresB, wrapAddr(nAccB));
    checkOutput("wrDataB", ramDataB, value);
    @(negedge clk);
    checkOutput("rdEnB", ramWrB, 0);
    checkOutput("rdAddrB", ramAdresB, wrapAddr(nAccB));
    checkOutput("smpEarlyB", smpValidB, 0);
    @(negedge clk);
    checkOutput("smpValidB", smpValidB, 1);
    checkOutput("smpDataB", smpDataB, value);
    checkOutput("tapIdxB", tapIdxB, 0);
    checkOutput("firstLastB", {smpFirstB, smpLastB}, 2'b11);
    @(negedge clk);
    checkOutput("readyBackB", inReadyB, 1);
    checkOutput("smpDoneB", smpValidB, 0);
    nAccB++;
  endtask

  initial begin
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inValidB = 1'b0;
    inDataB  = '0;
    repeat (3) @(negedge clk);
    checkClear();

    applyStimulus(16'h1234, 1'b0);

    for (int v = 1; v <= 5; v++) begin
      idleGap();
      applyStimulus(DW'(v), 1'b0);
    end

    for (int v = 0; v < 33; v++) begin
      idleGap();
      applyStimulus(DW'($urandom), 1'b0);
    end

    for (int v = 0; v < 10; v++) applyStimulus(DW'($urandom), 1'b1);
    inValid  = 1'b0;
    heldPrev = 1'b0;

    // Reset pulse while the burst is in its READ phase.
    idleGap();
    applyStimulus(DW'($urandom), 1'b0);
    inValid = 1'b1;
    inData  = DW'($urandom);
    for (int w = 0; w < 50 && inReady !== 1'b1; w++) @(negedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midBurstSmp", smpValid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkClear();

    for (int v = 0; v < 6; v++) begin
      idleGap();
      applyStimulus(DW'($urandom), 1'b0);
    end

    for (int v = 0; v < 4; v++) begin
      idleGap();
      applyStimulusB(DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
